// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: next-PC select, redirect buffering across stalls, IF/ID register.
// Optional FETCH_PERF_CNT_EN adds saturating stall/flush/redirect counters.
module fetch_sequencer #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   NOP_INSTR = '0,
    parameter logic [WIDTH-1:0]   PC_RESET  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] instr_in,
    input  logic             stall,
    input  logic             flush,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    output logic [WIDTH-1:0] pc_next,
    output logic [WIDTH-1:0] ifid_instr,
    output logic [WIDTH-1:0] ifid_pc4,
    output logic             ifid_valid,
    output logic             redirect_pending
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_count,
    output logic [31:0]      redirect_count
`endif
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};

    logic [WIDTH-1:0] pc_plus4;
    logic             redirect;
    logic [WIDTH-1:0] live_target;
    logic             pend_valid;
    logic [WIDTH-1:0] pend_target;

    assign pc_plus4    = pc_in + WIDTH'(4);
    assign redirect    = jump | branch_taken;
    assign live_target = (jump ? jump_target : branch_target) & ALIGN_MASK;

    always_comb begin
        pc_next = pc_plus4;
        if (rst)             pc_next = PC_RESET;
        else if (stall)      pc_next = pc_in;
        else if (redirect)   pc_next = live_target;
        else if (pend_valid) pc_next = pend_target;
    end

    // A redirect seen while stalled is parked here until the first non-stall cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else if (stall && redirect) begin
            pend_valid  <= 1'b1;
            pend_target <= live_target;
        end else if (!stall && (redirect || pend_valid)) begin
            pend_valid  <= 1'b0;
        end
    end

    assign redirect_pending = pend_valid;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ifid_instr <= NOP_INSTR;
            ifid_pc4   <= '0;
            ifid_valid <= 1'b0;
        end else if (!stall) begin
            ifid_instr <= instr_in;
            ifid_pc4   <= pc_plus4;
            ifid_valid <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic redirect_sel;
    assign redirect_sel = !stall && (redirect || pend_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles   <= '0;
            flush_count    <= '0;
            redirect_count <= '0;
        end else begin
            if (stall && stall_cycles != '1)
                stall_cycles <= stall_cycles + 32'd1;
            if (flush && flush_count != '1)
                flush_count <= flush_count + 32'd1;
            if (redirect_sel && redirect_count != '1)
                redirect_count <= redirect_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; checks perf counters when FETCH_PERF_CNT_EN is defined.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in, instr_in;
    logic        stall, flush, branch_taken, jump;
    logic [31:0] branch_target, jump_target;
    logic [31:0] pc_next, ifid_instr, ifid_pc4;
    logic        ifid_valid, redirect_pending;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_count, redirect_count;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in),
        .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .pc_next(pc_next), .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4),
        .ifid_valid(ifid_valid), .redirect_pending(redirect_pending)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cycles(stall_cycles), .flush_count(flush_count),
        .redirect_count(redirect_count)
`endif
    );

    // clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_redirect(input logic j, input logic [31:0] jt,
                                  input logic b, input logic [31:0] bt);
        jump = j; jump_target = jt; branch_taken = b; branch_target = bt;
    endtask

    initial begin
        logic [31:0] exp_instr;
        rst = 1'b1; pc_in = '0; instr_in = '0; stall = 1'b0; flush = 1'b0;
        drive_redirect(1'b0, '0, 1'b0, '0);

        tick();
        #1;
        check("rst_pc_next", pc_next, 32'h0);
        check("rst_ifid_instr", ifid_instr, 32'h0);
        check("rst_ifid_pc4", ifid_pc4, 32'h0);
        check("rst_ifid_valid", {31'b0, ifid_valid}, 32'h0);
        check("rst_pending", {31'b0, redirect_pending}, 32'h0);

        // sequential fetch
        rst = 1'b0; pc_in = 32'h0; instr_in = 32'h2008_0005;
        exp_q.push_back(32'h2008_0005);
        #1 check("seq0_pc_next", pc_next, 32'h4);
        tick();
        exp_instr = exp_q.pop_front();
        check("seq0_ifid_instr", ifid_instr, exp_instr);
        check("seq0_ifid_pc4", ifid_pc4, 32'h4);
        check("seq0_ifid_valid", {31'b0, ifid_valid}, 32'h1);
        pc_in = 32'h4; instr_in = 32'h8C09_0000;
        exp_q.push_back(32'h8C09_0000);
        #1 check("seq1_pc_next", pc_next, 32'h8);
        tick();
        exp_instr = exp_q.pop_front();
        check("seq1_ifid_instr", ifid_instr, exp_instr);
        check("seq1_ifid_pc4", ifid_pc4, 32'h8);

        // redirect priority and alignment
        drive_redirect(1'b1, 32'h400, 1'b1, 32'h100);
        #1 check("jump_over_branch", pc_next, 32'h400);
        drive_redirect(1'b1, 32'h403, 1'b1, 32'h100);
        #1 check("jump_misaligned", pc_next, 32'h400);
        drive_redirect(1'b0, 32'h0, 1'b1, 32'h102);
        #1 check("branch_misaligned", pc_next, 32'h100);
        tick();
        check("no_pend_unstalled", {31'b0, redirect_pending}, 32'h0);

        // stall with redirect in first cycle only
        stall = 1'b1; pc_in = 32'h10; instr_in = 32'h1111_1111;
        drive_redirect(1'b0, 32'h0, 1'b1, 32'h80);
        #1 check("stall1_pc_next", pc_next, 32'h10);
        tick();
        check("stall1_pending", {31'b0, redirect_pending}, 32'h1);
        check("stall1_hold_instr", ifid_instr, 32'h8C09_0000);
        check("stall1_hold_pc4", ifid_pc4, 32'h8);
        drive_redirect(1'b0, 32'h0, 1'b0, 32'h0);
        #1 check("stall2_pc_next", pc_next, 32'h10);
        tick();
        check("stall2_pending", {31'b0, redirect_pending}, 32'h1);
        check("stall2_hold_instr", ifid_instr, 32'h8C09_0000);
        tick();
        stall = 1'b0;
        #1 check("release_pc_next", pc_next, 32'h80);
        tick();
        check("release_pending", {31'b0, redirect_pending}, 32'h0);
        check("release_ifid_instr", ifid_instr, 32'h1111_1111);
        check("release_ifid_pc4", ifid_pc4, 32'h14);

        // newer redirect overwrites pending; live beats pending
        stall = 1'b1;
        drive_redirect(1'b1, 32'h200, 1'b0, 32'h0);
        tick();
        drive_redirect(1'b0, 32'h0, 1'b1, 32'h300);
        tick();
        stall = 1'b0;
        drive_redirect(1'b0, 32'h0, 1'b0, 32'h0);
        #1 check("pend_overwrite", pc_next, 32'h300);
        drive_redirect(1'b1, 32'h500, 1'b0, 32'h0);
        #1 check("live_beats_pend", pc_next, 32'h500);
        tick();
        check("live_clears_pend", {31'b0, redirect_pending}, 32'h0);

        // flush beats stall, pending kept
        stall = 1'b1;
        drive_redirect(1'b0, 32'h0, 1'b1, 32'h600);
        tick();
        drive_redirect(1'b0, 32'h0, 1'b0, 32'h0);
        flush = 1'b1;
        tick();
        check("flush_instr", ifid_instr, 32'h0);
        check("flush_pc4", ifid_pc4, 32'h0);
        check("flush_valid", {31'b0, ifid_valid}, 32'h0);
        check("flush_keeps_pend", {31'b0, redirect_pending}, 32'h1);
        flush = 1'b0; stall = 1'b0;
        #1 check("flush_pend_pc_next", pc_next, 32'h600);
        tick();
        check("flush_pend_consumed", {31'b0, redirect_pending}, 32'h0);

        // wrap
        pc_in = 32'hFFFF_FFFC; instr_in = 32'h3333_3333;
        #1 check("wrap_pc_next", pc_next, 32'h0);
        tick();
        check("wrap_ifid_pc4", ifid_pc4, 32'h0);
        check("wrap_ifid_valid", {31'b0, ifid_valid}, 32'h1);

        // reset with pending redirect
        stall = 1'b1;
        drive_redirect(1'b0, 32'h0, 1'b1, 32'h700);
        tick();
        check("pre_rst_pending", {31'b0, redirect_pending}, 32'h1);
        rst = 1'b1;
        #1 check("midrst_pc_next", pc_next, 32'h0);
        tick();
        check("midrst_pending", {31'b0, redirect_pending}, 32'h0);
        check("midrst_valid", {31'b0, ifid_valid}, 32'h0);
        check("midrst_instr", ifid_instr, 32'h0);
        rst = 1'b0; stall = 1'b0; pc_in = 32'h20;
        drive_redirect(1'b0, 32'h0, 1'b0, 32'h0);
        #1 check("post_rst_pc_next", pc_next, 32'h24);

`ifdef FETCH_PERF_CNT_EN
        check("perf_stall_zero", stall_cycles, 32'h0);
        check("perf_flush_zero", flush_count, 32'h0);
        check("perf_redir_zero", redirect_count, 32'h0);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        stall = 1'b0; flush = 1'b1;
        for (int i = 0; i < 2; i++) tick();
        flush = 1'b0;
        drive_redirect(1'b0, 32'h0, 1'b1, 32'h40);
        for (int i = 0; i < 3; i++) tick();
        drive_redirect(1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        check("perf_stall", stall_cycles, 32'd5);
        check("perf_flush", flush_count, 32'd2);
        check("perf_redir", redirect_count, 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("perf_stall_rst", stall_cycles, 32'h0);
        check("perf_flush_rst", flush_count, 32'h0);
        check("perf_redir_rst", redirect_count, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch stage logic between the program counter register and the decode stage of the 5-stage MIPS pipeline.
- Consumes the current PC and the instruction-memory read data.
- Computes the next PC (sequential, branch or jump redirect) and feeds it back to the PC register's input.
- Owns the IF/ID pipeline register, with stall-hold, flush-to-bubble, and a one-entry buffer that keeps a redirect received during a stall.

Parameters:
- WIDTH, 32, address/instruction width.
- NOP_INSTR, 32'h0000_0000, bubble instruction inserted on reset/flush.
- PC_RESET, 32'h0000_0000, value driven on pc_next while rst is high.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- pc_in  input  WIDTH  current PC from the PC register output
- instr_in  input  WIDTH  instruction-memory data for pc_in, valid in the same cycle
- stall  input  1  hazard unit: hold PC and IF/ID
- flush  input  1  squash IF/ID contents (wrong-path fetch)
- branch_taken  input  1  resolved taken branch
- branch_target  input  WIDTH  branch target address
- jump  input  1  jump request
- jump_target  input  WIDTH  jump target address
- pc_next  output  WIDTH  next PC to the PC register input; combinational
- ifid_instr  output  WIDTH  IF/ID instruction
- ifid_pc4  output  WIDTH  IF/ID PC+4
- ifid_valid  output  1  IF/ID holds a real instruction
- redirect_pending  output  1  buffered redirect awaiting stall release

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high.
- pc_plus4 = pc_in + 4, modulo 2^WIDTH; 32'hFFFF_FFFC wraps to 0.
- Live redirect: redirect = jump | branch_taken; target = jump ? jump_target : branch_target. Jump has priority. target[1:0] is forced to 2'b00.
- pc_next priority (combinational):
  1. rst → PC_RESET
  2. stall → pc_in (hold)
  3. live redirect → target
  4. redirect_pending → buffered target
  5. otherwise → pc_plus4
- Pending buffer (pend_valid, pend_target), updated on posedge:
  - rst → pend_valid = 0, pend_target = 0.
  - stall & redirect → capture target, pend_valid = 1. A newer redirect overwrites an older pending one.
  - !stall & (redirect | pend_valid) → pend_valid = 0. The redirect is consumed by pc_next this cycle; a live redirect beats the pending one.
  - flush does not clear the pending buffer.
- redirect_pending = pend_valid (registered).
- IF/ID register, on posedge, in priority order:
  1. rst → ifid_instr = NOP_INSTR, ifid_pc4 = 0, ifid_valid = 0.
  2. flush → same values as reset. Flush beats stall.
  3. stall → hold all three.
  4. otherwise → ifid_instr = instr_in, ifid_pc4 = pc_plus4, ifid_valid = 1.
- Latency: instruction at pc_in appears on the IF/ID outputs 1 cycle later. A redirect changes pc_next in the same cycle, or in the first non-stall cycle if it was buffered.
- Reset mid-operation: all state is cleared on the next edge and pending redirects are discarded.
- No X on any output after the first reset edge.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, adds output ports:
  - stall_cycles (32): increments every non-reset cycle with stall=1.
  - flush_count (32): increments on every flush.
  - redirect_count (32): increments each cycle pc_next selects a live or buffered redirect.
  - All three reset to 0 and saturate at 32'hFFFF_FFFF.
- When undefined, these ports and counters do not exist; remaining behaviour is identical.

Test Plan:
- Reset then sequential fetch: rst 1 cycle, then pc_in=0x0, instr_in=0x2008_0005 → pc_next=0x4; next cycle ifid_instr=0x2008_0005, ifid_pc4=0x4, ifid_valid=1.
- Redirect priority: jump=1 (jump_target=0x0000_0400), branch_taken=1 (branch_target=0x0000_0100) → pc_next=0x400. Misaligned jump_target=0x0000_0403 → pc_next=0x400.
- Stall with redirect: stall=1 for 3 cycles, branch_taken=1 (target 0x80) in cycle 1 only → pc_next=pc_in while stalled, redirect_pending=1, IF/ID held. First cycle with stall=0 → pc_next=0x80; redirect_pending=0 after that edge.
- Flush beats stall: stall=1 and flush=1 together → ifid_instr=0x0000_0000, ifid_valid=0; a pending redirect is retained.
- Wrap and mid-run reset: pc_in=0xFFFF_FFFC → pc_next=0x0. Assert rst while redirect_pending=1 → pending cleared, ifid_valid=0, pc_next=PC_RESET during rst.
- With FETCH_PERF_CNT_EN: 5 stall cycles, 2 flushes, 3 redirects → stall_cycles=5, flush_count=2, redirect_count=3; all 0 after rst.
